// File: rtl/iter_mult_hs.sv
// ============================================================================
// Module      : iter_mult_hs
// Description : Iterative shift-add unsigned multiplier with valid/ready
//               handshakes. Optional truncation via `define APPROX_TRUNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_mult_hs #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 0,
    parameter int TRUNC_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);

    localparam int c_PW = 2 * WIDTH;
    localparam int c_CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    generate
        if (TRUNC_BITS < 0 || TRUNC_BITS > 2 * WIDTH - 1) begin : g_bad_trunc
            $error("iter_mult_hs: TRUNC_BITS out of range");
        end
    endgenerate

    state_t             r_state;
    logic [c_PW-1:0]    r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_PW-1:0]    r_acc;
    logic [c_CW-1:0]    r_cnt;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_out_valid;
    logic [c_PW-1:0]    r_p;

    logic [c_PW-1:0]    w_pp;
    logic [c_PW-1:0]    w_acc_next;
    logic               w_last;

`ifdef APPROX_TRUNC_EN
    localparam logic [c_PW-1:0] c_TRUNC_MASK = {c_PW{1'b1}} << TRUNC_BITS;
    assign w_pp = r_a & c_TRUNC_MASK;
`else
    assign w_pp = r_a;
`endif

    assign w_acc_next = r_b[0] ? (r_acc + w_pp) : r_acc;

    // Early exit looks at the multiplier as it will be after this shift.
    assign w_last = (r_cnt == c_CW'(WIDTH - 1)) ||
                    ((EARLY_EXIT != 0) && ((r_b >> 1) == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_p         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= {{WIDTH{1'b0}}, A};
                        r_b        <= B;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_state    <= S_CALC;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_p         <= w_acc_next;
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign P         = r_p;

endmodule

`default_nettype wire

// File: tb/tb_iter_mult_hs.sv
// ============================================================================
// Module      : tb_iter_mult_hs
// Description : Self-checking bench; instance 0 has EARLY_EXIT=0, 1 has =1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_mult_hs;

    localparam int W  = 8;
    localparam int TB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [W-1:0] a_in     [2];
    logic [W-1:0] b_in     [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [2*W-1:0] p_out  [2];
    logic        busy      [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iter_mult_hs #(.WIDTH(W), .EARLY_EXIT(0), .TRUNC_BITS(TB)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(a_in[0]), .B(b_in[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .P(p_out[0]), .busy(busy[0])
    );

    iter_mult_hs #(.WIDTH(W), .EARLY_EXIT(1), .TRUNC_BITS(TB)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(a_in[1]), .B(b_in[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .P(p_out[1]), .busy(busy[1])
    );

    typedef struct {
        int d;
        int a;
        int b;
        int exp_p;
        int exp_lat;
        int bp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: sum of (possibly truncated) partial products.
    function automatic int ref_mul(input int a, input int b);
        int s;
        s = 0;
        for (int i = 0; i < W; i++) begin
            if ((b >> i) & 1) begin
`ifdef APPROX_TRUNC_EN
                s += ((a << i) / (1 << TB)) * (1 << TB);
`else
                s += a << i;
`endif
            end
        end
        return s;
    endfunction

    function automatic int ref_lat(input int ee, input int b);
        int msb;
        if (ee == 0) return W;
        msb = 0;
        for (int i = 0; i < W; i++)
            if ((b >> i) & 1) msb = i;
        return (msb + 1 < 1) ? 1 : msb + 1;
    endfunction

    task automatic run_txn(input int d, input int a, input int b, input int exp_p,
                           input int exp_lat, input int bp, input bit eager);
        int k;
        int busy_cnt;
        k = 0;
        while (!in_ready[d] && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("ready_before_accept", longint'(in_ready[d]), 1);
        in_valid[d] = 1'b1;
        a_in[d] = W'(a);
        b_in[d] = W'(b);
        if (eager) out_ready[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        a_in[d] = W'($urandom);
        b_in[d] = W'($urandom);
        chk("ready_low_after_accept", longint'(in_ready[d]), 0);
        k = 0;
        busy_cnt = 0;
        while (!out_valid[d] && k < W + 4) begin
            if (busy[d]) busy_cnt++;
            @(posedge clk); #1; k++;
        end
        chk("latency", k, exp_lat);
        chk("busy_cycles", busy_cnt, exp_lat);
        chk("product", longint'(p_out[d]), exp_p);
        chk("busy_low_in_done", longint'(busy[d]), 0);
        if (eager) begin
            @(posedge clk); #1;
            out_ready[d] = 1'b0;
            chk("eager_valid_drop", longint'(out_valid[d]), 0);
            chk("eager_ready_back", longint'(in_ready[d]), 1);
        end else begin
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                chk("bp_valid_hold", longint'(out_valid[d]), 1);
                chk("bp_p_hold", longint'(p_out[d]), exp_p);
                chk("bp_ready_low", longint'(in_ready[d]), 0);
            end
            out_ready[d] = 1'b1;
            @(posedge clk); #1;
            out_ready[d] = 1'b0;
            chk("release_valid_drop", longint'(out_valid[d]), 0);
            chk("release_ready_back", longint'(in_ready[d]), 1);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b1;
            out_ready[d] = 1'b0;
            a_in[d]      = 8'd9;
            b_in[d]      = 8'd9;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("reset_in_ready", longint'(in_ready[d]), 1);
            chk("reset_out_valid", longint'(out_valid[d]), 0);
            chk("reset_busy", longint'(busy[d]), 0);
            chk("reset_p", longint'(p_out[d]), 0);
        end
        @(posedge clk); #1;
        chk("idle_stays_idle", longint'(busy[0]), 0);

`ifdef APPROX_TRUNC_EN
        vecs.push_back('{0, 255, 255, 64976, 8, 5});
        vecs.push_back('{0,   1,   1,     0, 8, 0});
        vecs.push_back('{0,  16,   3,    48, 8, 1});
        vecs.push_back('{1,  16,   3,    48, 2, 0});
        vecs.push_back('{1, 255, 255, 64976, 8, 2});
`else
        vecs.push_back('{0,  13,  11,   143, 8, 5});
        vecs.push_back('{0, 255, 255, 65025, 8, 0});
        vecs.push_back('{0,   0, 200,     0, 8, 1});
        vecs.push_back('{0,   1, 128,   128, 8, 0});
        vecs.push_back('{1,  99,   0,     0, 1, 0});
        vecs.push_back('{1,   7,   5,    35, 3, 2});
        vecs.push_back('{1,   1, 128,   128, 8, 0});
        vecs.push_back('{1, 255, 255, 65025, 8, 0});
`endif
        foreach (vecs[i])
            run_txn(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].exp_p,
                    vecs[i].exp_lat, vecs[i].bp, 1'b0);

        // Abort mid-calculation and confirm a clean restart.
        in_valid[0] = 1'b1;
        a_in[0] = 8'd200;
        b_in[0] = 8'd100;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_before_abort", longint'(busy[0]), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", longint'(in_ready[0]), 1);
        chk("abort_out_valid", longint'(out_valid[0]), 0);
        chk("abort_p", longint'(p_out[0]), 0);
        chk("abort_busy", longint'(busy[0]), 0);
        run_txn(0, 3, 4, ref_mul(3, 4), W, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int d, a, b;
            d = n % 2;
            a = int'($urandom_range(0, 255));
            b = (n % 4 == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
            run_txn(d, a, b, ref_mul(a, b), ref_lat(d, b),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
